// File: rtl/uart_tx_word.sv
// uart_tx_word: sends a 16-bit word as two UART frames, high byte first, with its own baud generator
module uart_tx_word #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD      = 9600,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] word,
  output logic        txd,
  output logic        busy,
  output logic        done
);
  localparam int BAUD_DIV = CLK_FREQ / BAUD;
  localparam int BW = BAUD_DIV > 2 ? $clog2(BAUD_DIV) : 1;
  localparam logic [BW-1:0] LAST = BW'(BAUD_DIV - 1);
  localparam bit PAR_EN = PARITY == 1 || PARITY == 2;
  localparam bit PAR_ODD = PARITY == 1;

  if (BAUD_DIV < 2) begin : g_bad_div
    $error("uart_tx_word: BAUD_DIV must be at least 2");
  end

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  state_t        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic          stop_q, stop_d;
  logic          sel_q, sel_d;
  logic [15:0]   word_q, word_d;
  logic          txd_q, txd_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [7:0]    cur;
  logic          tick;

  // Next-state and next-output logic; the line level is decided one bit ahead so txd is a flop
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    stop_d  = stop_q;
    sel_d   = sel_q;
    word_d  = word_q;
    txd_d   = txd_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    cur     = sel_q ? word_q[7:0] : word_q[15:8];
    tick    = baud_q == LAST;
    if (state_q != IDLE) baud_d = tick ? '0 : baud_q + 1'b1;
    unique case (state_q)
      IDLE: if (start) begin
        state_d = START;
        word_d  = word;
        sel_d   = 1'b0;
        baud_d  = '0;
        busy_d  = 1'b1;
        txd_d   = 1'b0;
      end
      START: if (tick) begin
        state_d = DATA;
        bit_d   = '0;
        txd_d   = cur[0];
      end
      DATA: if (tick) begin
        if (bit_q == 3'd7) begin
          state_d = PAR_EN ? PAR : STOP;
          txd_d   = PAR_EN ? (^cur ^ PAR_ODD) : 1'b1;
          stop_d  = 1'b0;
        end else begin
          bit_d = bit_q + 1'b1;
          txd_d = cur[bit_q + 3'd1];
        end
      end
      PAR: if (tick) begin
        state_d = STOP;
        txd_d   = 1'b1;
        stop_d  = 1'b0;
      end
      STOP: if (tick) begin
        if (STOP_BITS == 2 && !stop_q) stop_d = 1'b1;
        else if (!sel_q) begin
          sel_d   = 1'b1;
          state_d = START;
          txd_d   = 1'b0;
        end else begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          txd_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset aborts any frame in progress and idles the line
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      stop_q  <= 1'b0;
      sel_q   <= 1'b0;
      word_q  <= '0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      sel_q   <= sel_d;
      word_q  <= word_d;
      txd_q   <= txd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign txd  = txd_q;
  assign busy = busy_q;
  assign done = done_q;
endmodule

// File: tb/tb_uart_tx_word.sv
// tb_uart_tx_word: scoreboard bench decoding the serial line of three parity/stop configurations
module tb_uart_tx_word;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  start_v = '0;
  logic [15:0] word_a [3];
  wire  [2:0]  txd_v, busy_v, done_v;
  logic [7:0]  exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          nfr = 0;
  int          dcnt [3];

  always #5 clk = ~clk;

  uart_tx_word #(.CLK_FREQ(8), .BAUD(1), .PARITY(0), .STOP_BITS(1)) u_dut0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .word(word_a[0]),
    .txd(txd_v[0]), .busy(busy_v[0]), .done(done_v[0]));
  uart_tx_word #(.CLK_FREQ(8), .BAUD(1), .PARITY(2), .STOP_BITS(2)) u_dut1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .word(word_a[1]),
    .txd(txd_v[1]), .busy(busy_v[1]), .done(done_v[1]));
  uart_tx_word #(.CLK_FREQ(8), .BAUD(1), .PARITY(1), .STOP_BITS(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start_v[2]), .word(word_a[2]),
    .txd(txd_v[2]), .busy(busy_v[2]), .done(done_v[2]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // counts done pulses per instance, sampled mid-cycle
  always @(negedge clk)
    for (int i = 0; i < 3; i++) dcnt[i] += int'(done_v[i]);

  task automatic step(input int n, inout logic ab);
    repeat (n) begin
      @(negedge clk);
      if (!rst) ab = 1'b1;
    end
  endtask

  // decodes frames on one line at mid-bit and compares against the scoreboard
  task automatic mon(input int g, input int par, input int sb);
    logic       ab, st, p, s1, s2;
    logic [7:0] b, e;
    forever begin
      @(negedge clk);
      if (!rst || txd_v[g]) continue;
      ab = 1'b0;
      p  = 1'b0;
      s2 = 1'b1;
      step(3, ab); st = txd_v[g];
      for (int i = 0; i < 8; i++) begin step(8, ab); b[i] = txd_v[g]; end
      if (par != 0) begin step(8, ab); p = txd_v[g]; end
      step(8, ab); s1 = txd_v[g];
      if (sb == 2) begin step(8, ab); s2 = txd_v[g]; end
      if (ab) continue;
      nfr++;
      if (exp_q.size() == 0) begin
        check("unexpected_frame", {24'd0, b}, 32'hFFFF_FFFF);
        continue;
      end
      e = exp_q.pop_front();
      check("start_bit", st, 0);
      check("data_byte", b, e);
      if (par != 0) check("parity_bit", p, par == 2 ? ^e : ~^e);
      check("stop_bits", {s2, s1}, 2'b11);
    end
  endtask

  initial mon(0, 0, 1);
  initial mon(1, 2, 2);
  initial mon(2, 1, 2);

  task automatic go(input int g, input logic [15:0] w);
    start_v[g] = 1'b1;
    word_a[g]  = w;
    exp_q.push_back(w[15:8]);
    exp_q.push_back(w[7:0]);
    @(negedge clk);
    start_v[g] = 1'b0;
    check("busy_on", busy_v[g], 1);
    check("txd_start_now", txd_v[g], 0);
  endtask

  task automatic wait_done(input int g, input int lat);
    int   n = 0;
    logic drop = 1'b0;
    while (!done_v[g] && n < 2000) begin
      drop |= !busy_v[g];
      @(negedge clk);
      n++;
    end
    check("latency", n, lat);
    check("busy_held", drop, 0);
    check("busy_off", busy_v[g], 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int   d0;
    logic bad, drop;
    for (int i = 0; i < 3; i++) word_a[i] = '0;
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_txd", txd_v, 3'b111);
    check("rst_busy", busy_v, 3'b000);
    check("rst_done", done_v, 3'b000);
    rst = 1'b1;
    bad = 1'b0;
    repeat (200) begin
      @(negedge clk);
      bad |= (txd_v != 3'b111) || (busy_v != 3'b000);
    end
    check("idle_line", bad, 0);

    d0 = dcnt[0];
    go(0, 16'hA53C);
    wait_done(0, 160);
    @(negedge clk);
    check("done_one_cycle", done_v[0], 0);
    check("done_count_a53c", dcnt[0] - d0, 1);

    d0 = dcnt[0];
    drop = 1'b0;
    go(0, 16'h1234);
    repeat (40) begin @(negedge clk); drop |= !busy_v[0]; end
    start_v[0] = 1'b1;
    word_a[0]  = 16'hFFFF;
    @(negedge clk);
    start_v[0] = 1'b0;
    check("busy_retrig", drop | !busy_v[0], 0);
    wait_done(0, 119);
    repeat (20) @(negedge clk);
    check("done_count_retrig", dcnt[0] - d0, 1);

    d0 = dcnt[0];
    go(0, 16'h8001);
    wait_done(0, 160);
    go(0, 16'h00FF);
    wait_done(0, 160);
    repeat (20) @(negedge clk);
    check("done_count_b2b", dcnt[0] - d0, 2);

    go(1, 16'h0701);
    wait_done(1, 192);
    repeat (20) @(negedge clk);
    go(2, 16'h0701);
    wait_done(2, 192);
    repeat (20) @(negedge clk);
    check("q_empty_mid", exp_q.size(), 0);

    go(0, 16'hC3C3);
    repeat (35) @(negedge clk);
    #1 rst = 1'b0;
    #1;
    check("async_rst_txd", txd_v[0], 1);
    check("async_rst_busy", busy_v[0], 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (200) @(negedge clk);
    check("post_rst_busy", busy_v[0], 0);
    go(0, 16'h5AA5);
    wait_done(0, 160);
    repeat (20) @(negedge clk);

    check("q_empty_end", exp_q.size(), 0);
    check("frames_decoded", nfr, 14);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
